// File: rtl/i2c_ball_tx_seq_pkg.sv
// i2c_ball_tx_seq_pkg: shared I2C command encodings, frame constants and FSM states
package i2c_ball_tx_seq_pkg;
  typedef enum logic [1:0] {CMD_START = 2'b00, CMD_WRITE = 2'b01, CMD_STOP = 2'b10} cmd_e;
  typedef enum logic [2:0] {IDLE, START, WR_BYTE, WAIT_ACK, STOP, GAP, FIN} state_e;
  localparam logic [7:0] REG_PTR = 8'h00;
  localparam int PAYLOAD_BYTES = 5;
  localparam int FRAME_BYTES = PAYLOAD_BYTES + 2;
  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);
  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return v < LAST_IDX ? v + 3'd1 : v;
  endfunction
endpackage

// File: rtl/i2c_gap_timer.sv
// i2c_gap_timer: counts the idle gap between a STOP and the retry START
module i2c_gap_timer #(
  parameter int GAP_CYC = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expire
);
  localparam int W = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
  logic [W-1:0] cnt;
  // load arms GAP_CYC-1 so the run cycles up to and including the expire cycle total GAP_CYC
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= W'(GAP_CYC - 1);
    else if (run && cnt != '0) cnt <= cnt - W'(1);
  assign expire = cnt == '0;
endmodule

// File: rtl/i2c_ball_tx_seq.sv
// i2c_ball_tx_seq: sequences the ball-handoff I2C write with NACK retry
module i2c_ball_tx_seq
  import i2c_ball_tx_seq_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int RETRY_MAX = 3,
  parameter int GAP_CYC = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_req,
  input  logic [7:0] y0,
  input  logic [7:0] y1,
  input  logic [7:0] yspeed,
  input  logic [7:0] gravity,
  input  logic [7:0] ballspeed,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       m_cmd_valid,
  output logic [1:0] m_cmd,
  output logic [7:0] m_tx_data,
  input  logic       m_cmd_ready,
  input  logic       m_ack_valid,
  input  logic       m_nack
);
  localparam int RW = RETRY_MAX > 0 ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [RW-1:0] RMAX = RW'(RETRY_MAX);
  state_e state, state_n;
  logic [2:0] idx, idx_n;
  logic [RW-1:0] rty, rty_n;
  logic nack, nack_n, fail, fail_n, retry, gap_load, gap_expire;
  logic [PAYLOAD_BYTES*8-1:0] snap, snap_n;
  logic [63:0] frame;
  assign frame = {8'h00, snap, REG_PTR, SLAVE_ADDR, 1'b0};
  i2c_gap_timer #(.GAP_CYC(GAP_CYC)) u_gap (
    .clk(clk),
    .rst(reset),
    .load(gap_load),
    .run(state == GAP),
    .expire(gap_expire)
  );
  // state, counters, flags and payload snapshot
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      rty <= '0;
      nack <= 1'b0;
      fail <= 1'b0;
      snap <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      rty <= rty_n;
      nack <= nack_n;
      fail <= fail_n;
      snap <= snap_n;
    end
  // next state and Moore command outputs; commands hold while the core stalls
  always_comb begin
    state_n = state;
    idx_n = idx;
    rty_n = rty;
    nack_n = nack;
    fail_n = fail;
    snap_n = snap;
    retry = 1'b0;
    gap_load = 1'b0;
    m_cmd_valid = 1'b0;
    m_cmd = CMD_START;
    m_tx_data = 8'h00;
    done = 1'b0;
    err = 1'b0;
    busy = state != IDLE && state != FIN;
    case (state)
      IDLE: if (send_req) begin
        snap_n = {ballspeed, gravity, yspeed, y1, y0};
        idx_n = '0;
        rty_n = '0;
        nack_n = 1'b0;
        fail_n = 1'b0;
        state_n = START;
      end
      START: begin
        m_cmd_valid = 1'b1;
        if (m_cmd_ready) begin
          idx_n = '0;
          state_n = WR_BYTE;
        end
      end
      WR_BYTE: begin
        m_cmd_valid = 1'b1;
        m_cmd = CMD_WRITE;
        m_tx_data = frame[{idx, 3'b000} +: 8];
        if (m_cmd_ready) state_n = WAIT_ACK;
      end
      WAIT_ACK: if (m_ack_valid) begin
        nack_n = m_nack;
        idx_n = m_nack ? idx : sat_inc(idx);
        state_n = (m_nack || idx == LAST_IDX) ? STOP : WR_BYTE;
      end
      STOP: begin
        m_cmd_valid = 1'b1;
        m_cmd = CMD_STOP;
        if (m_cmd_ready) begin
          retry = nack && rty < RMAX;
          rty_n = retry ? rty + RW'(1) : rty;
          nack_n = nack && !retry;
          fail_n = nack && !retry;
          gap_load = retry;
          state_n = retry ? GAP : FIN;
        end
      end
      GAP: if (gap_expire) begin
        idx_n = '0;
        state_n = START;
      end
      FIN: begin
        done = !fail;
        err = fail;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_i2c_ball_tx_seq.sv
// tb_i2c_ball_tx_seq: randomized check of the ball-handoff sequencer against a frame-level model
module tb_i2c_ball_tx_seq;
  localparam int GAP = 100;
  localparam int RMAX = 3;
  localparam logic [6:0] ADDR = 7'h42;
  logic clk = 1'b0, reset = 1'b1, send_req = 1'b0;
  logic [7:0] y0 = 0, y1 = 0, yspeed = 0, gravity = 0, ballspeed = 0;
  logic busy, done, err, m_cmd_valid, m_cmd_ready, m_ack_valid, m_nack;
  logic [1:0] m_cmd;
  logic [7:0] m_tx_data;
  i2c_ball_tx_seq #(.SLAVE_ADDR(ADDR), .RETRY_MAX(RMAX), .GAP_CYC(GAP)) dut (
    .clk(clk),
    .reset(reset),
    .send_req(send_req),
    .y0(y0),
    .y1(y1),
    .yspeed(yspeed),
    .gravity(gravity),
    .ballspeed(ballspeed),
    .busy(busy),
    .done(done),
    .err(err),
    .m_cmd_valid(m_cmd_valid),
    .m_cmd(m_cmd),
    .m_tx_data(m_tx_data),
    .m_cmd_ready(m_cmd_ready),
    .m_ack_valid(m_ack_valid),
    .m_nack(m_nack)
  );
  always #5 clk = ~clk;
  int vecs = 0, errs = 0;
  int ready_mode = 0, ack_mode = 0, hold_at = -1, bp_left = 0;
  bit spurious = 0;
  logic [7:0] bp_byte = 0;
  logic [6:0] plan [8];
  logic [7:0] pay [5];
  logic [9:0] log_q [$];
  logic [9:0] exp_q [$];
  bit exp_err;
  int exp_cyc;
  int att = 0, bi = 0, pdly = 0;
  bit pend = 0, phold = 0, pnack = 0, stall = 0;
  logic [9:0] stall_v;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // expected frames, outcome and ideal latency straight from the transfer rules
  task automatic build_model();
    logic [7:0] bytes [7];
    bytes[0] = {ADDR, 1'b0};
    bytes[1] = 8'h00;
    for (int k = 0; k < 5; k++) bytes[k+2] = pay[k];
    exp_q.delete();
    exp_err = 0;
    exp_cyc = 2;
    for (int a = 0; a <= RMAX; a++) begin
      int n;
      bit nk;
      n = 0;
      nk = 0;
      exp_q.push_back({2'b00, 8'h00});
      for (int b = 0; b < 7; b++) begin
        exp_q.push_back({2'b01, bytes[b]});
        n++;
        if (plan[a][b]) begin
          nk = 1;
          break;
        end
      end
      exp_q.push_back({2'b10, 8'h00});
      exp_cyc += 2 + 2 * n;
      if (!nk) break;
      if (a == RMAX) exp_err = 1;
      else exp_cyc += GAP;
    end
  endtask
  // I2C master core stand-in: ready policy, ack responses, transfer log, hold checks
  initial begin
    m_cmd_ready = 0;
    m_ack_valid = 0;
    m_nack = 0;
    forever begin
      @(posedge clk);
      #1;
      m_ack_valid = 0;
      m_nack = 0;
      if (reset) begin
        pend = 0;
        phold = 0;
      end else if (pend && !phold) begin
        if (pdly == 0) begin
          m_ack_valid = 1;
          m_nack = pnack;
          pend = 0;
        end else pdly--;
      end else if (!pend && spurious && $urandom_range(9) == 0) begin
        m_ack_valid = 1;
        m_nack = 1'($urandom_range(1));
      end
      if (ready_mode == 1) m_cmd_ready = $urandom_range(9) < 7;
      else if (ready_mode == 2 && m_cmd_valid && m_cmd == 2'b01 && m_tx_data == bp_byte && bp_left > 0) begin
        m_cmd_ready = 0;
        bp_left--;
      end else m_cmd_ready = 1;
      @(negedge clk);
      if (stall && !reset) begin
        chk("hold_valid", m_cmd_valid, 1);
        chk("hold_cmd", {m_cmd, m_tx_data}, stall_v);
      end
      stall = m_cmd_valid && !m_cmd_ready && !reset;
      stall_v = {m_cmd, m_tx_data};
      if (m_cmd_valid && m_cmd_ready && !reset) begin
        log_q.push_back({m_cmd, m_cmd == 2'b01 ? m_tx_data : 8'h00});
        if (m_cmd == 2'b00) begin
          att++;
          bi = 0;
        end else if (m_cmd == 2'b01) begin
          pend = 1;
          phold = bi == hold_at;
          pdly = ack_mode ? $urandom_range(3) : 0;
          pnack = (att >= 1 && att <= 8) ? plan[att-1][bi] : 1'b0;
          if (bi < 6) bi++;
        end
      end
    end
  end
  task automatic run(input bit extra, input bit chk_lat, input string tag);
    int cyc;
    bit seen;
    build_model();
    log_q.delete();
    att = 0;
    @(posedge clk);
    #1;
    y0 = pay[0];
    y1 = pay[1];
    yspeed = pay[2];
    gravity = pay[3];
    ballspeed = pay[4];
    send_req = 1;
    cyc = 0;
    seen = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (i == 1) chk({tag, "_busy"}, busy, 1);
      if (done || err) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
      send_req = extra && (cyc == 3 || cyc == 10);
      y0 = 8'($urandom);
      y1 = 8'($urandom);
      yspeed = 8'($urandom);
      gravity = 8'($urandom);
      ballspeed = 8'($urandom);
    end
    chk({tag, "_fin"}, seen, 1);
    chk({tag, "_done"}, done, !exp_err);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_busy_end"}, busy, 0);
    if (chk_lat) chk({tag, "_lat"}, cyc, exp_cyc - 1);
    @(posedge clk);
    #1;
    send_req = 0;
    @(negedge clk);
    chk({tag, "_pulse"}, {done, err}, 2'b00);
    chk({tag, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) chk({tag, "_xfer"}, log_q[i], exp_q[i]);
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_valid"}, m_cmd_valid, 0);
    chk({tag, "_cmd"}, m_cmd, 0);
    chk({tag, "_data"}, m_tx_data, 0);
  endtask
  initial begin
    bit got6;
    for (int a = 0; a < 8; a++) plan[a] = '0;
    pay = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk);
    #1;
    reset = 0;
    run(0, 1, "nominal");
    ready_mode = 2;
    bp_byte = 8'h14;
    bp_left = 5;
    run(0, 0, "backpressure");
    chk("bp_stalls", bp_left, 0);
    ready_mode = 0;
    plan[0] = 7'b0100000;
    run(0, 1, "nack_gravity");
    for (int a = 0; a < 8; a++) plan[a] = 7'b0000001;
    run(0, 1, "nack_addr");
    for (int a = 0; a < 8; a++) plan[a] = '0;
    run(1, 1, "busy_req");
    repeat (20) @(negedge clk);
    chk("busy_req_single", log_q.size(), 9);
    chk("busy_req_idle", busy, 0);
    hold_at = 4;
    log_q.delete();
    att = 0;
    @(posedge clk);
    #1;
    y0 = pay[0];
    y1 = pay[1];
    yspeed = pay[2];
    gravity = pay[3];
    ballspeed = pay[4];
    send_req = 1;
    @(posedge clk);
    #1;
    send_req = 0;
    got6 = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (log_q.size() >= 6) begin
        got6 = 1;
        break;
      end
    end
    chk("rst_wait", got6, 1);
    @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("mid_reset");
    @(posedge clk);
    #1;
    reset = 0;
    hold_at = -1;
    repeat (3) @(negedge clk);
    chk("rst_no_stop", log_q.size(), 6);
    if (log_q.size() >= 6) chk("rst_byte4", log_q[5], {2'b01, pay[2]});
    run(0, 1, "post_reset");
    spurious = 1;
    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < 5; k++) pay[k] = 8'($urandom);
      for (int a = 0; a < 8; a++) plan[a] = $urandom_range(3) == 0 ? 7'(1 << $urandom_range(6)) : 7'b0;
      ready_mode = $urandom_range(1);
      ack_mode = $urandom_range(1);
      run(0, ready_mode == 0 && ack_mode == 0, "random");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
